// File: rtl/aes_const.sv
// -----------------------------------------------------------------------------
// aes_const
//   Shared AES constants, types and GF(2^8) helpers used by the (Inv)MixColumns
//   datapath.
//   Contents:
//     Nb            columns per AES state
//     state_t       full state as a byte array [0:4*Nb-1], column c = bytes 4c..4c+3
//     mc_state_t    control FSM encoding for the MixColumns engine
//     gf_xtime      multiply by x (i.e. by 2) modulo 0x11B
//     gf_mul_const  multiply by one of the MixColumns constants 2,3,9,b,d,e
// -----------------------------------------------------------------------------
package aes_const;

  localparam int Nb = 4;

  typedef logic [0:4*Nb-1][7:0] state_t;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_BUSY,
    MC_DONE
  } mc_state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Every constant is a sum of powers of x, so the product is an XOR of an
  // xtime chain. Unsupported constants fall back to multiplication by 1.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    case (c)
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hB:    return x8 ^ x2 ^ b;
      4'hD:    return x8 ^ x4 ^ b;
      4'hE:    return x8 ^ x4 ^ x2;
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// -----------------------------------------------------------------------------
// aes_mixcol_col
//   Combinational single-column (Inv)MixColumns transform.
//   Ports:
//     col_in   in   4 bytes, row 0 first
//     mode     in   0 = MixColumns, 1 = InvMixColumns
//     col_out  out  transformed column, same byte ordering
// -----------------------------------------------------------------------------
module aes_mixcol_col
  import aes_const::*;
(
  input  logic [0:3][7:0] col_in,
  input  logic            mode,
  output logic [0:3][7:0] col_out
);

  // Row r uses the row-0 coefficient vector rotated right by r, so byte
  // (r+k)%4 is multiplied by coefficient k.
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] fwd, inv;

    assign fwd = gf_mul_const(col_in[r],         4'h2) ^
                 gf_mul_const(col_in[(r+1) % 4], 4'h3) ^
                 col_in[(r+2) % 4] ^
                 col_in[(r+3) % 4];

    assign inv = gf_mul_const(col_in[r],         4'hE) ^
                 gf_mul_const(col_in[(r+1) % 4], 4'hB) ^
                 gf_mul_const(col_in[(r+2) % 4], 4'hD) ^
                 gf_mul_const(col_in[(r+3) % 4], 4'h9);

    assign col_out[r] = mode ? inv : fwd;
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// -----------------------------------------------------------------------------
// aes_mixcol_engine
//   Sequential (Inv)MixColumns engine: accepts a full state, transforms
//   COLS_PER_CYC columns per cycle in place, then presents the result.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     in_valid   in   input state offered
//     in_ready   out  engine idle and able to accept
//     in_mode    in   0 = MixColumns, 1 = InvMixColumns (sampled on accept)
//     in_state   in   byte array [0:4*NB-1], column c = bytes 4c..4c+3
//     out_valid  out  result available
//     out_ready  in   consumer takes the result
//     out_state  out  transformed state, same ordering; zero unless out_valid
//     busy       out  transaction in progress or waiting to be taken
// -----------------------------------------------------------------------------
module aes_mixcol_engine
  import aes_const::*;
#(
  parameter int NB           = Nb,
  parameter int COLS_PER_CYC = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [0:4*NB-1][7:0]  in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:4*NB-1][7:0]  out_state,
  output logic                  busy
);

  // One extra bit so the post-increment value NB is representable.
  localparam int                CNT_W    = $clog2(NB) + 1;
  localparam int                IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NB - COLS_PER_CYC);
  localparam logic [CNT_W-1:0]  CNT_STEP = CNT_W'(COLS_PER_CYC);

  if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4) ||
      (NB % COLS_PER_CYC) != 0) begin : g_param_check
    $fatal(1, "aes_mixcol_engine: COLS_PER_CYC=%0d illegal for NB=%0d", COLS_PER_CYC, NB);
  end

  mc_state_t                  state_q, state_d;
  logic [0:4*NB-1][7:0]       work_q, work_d;
  logic [CNT_W-1:0]           col_cnt;
  logic                       mode_q;

  logic [0:3][7:0]            cols    [NB];
  logic [IDX_W-1:0]           col_idx [COLS_PER_CYC];
  logic [0:3][7:0]            col_in  [COLS_PER_CYC];
  logic [0:3][7:0]            col_out [COLS_PER_CYC];

  // ---------------------------------------------------------------------------
  // Column datapath: gather the current group, transform, scatter back.
  // Groups are aligned to COLS_PER_CYC, so column c always goes through lane
  // c % COLS_PER_CYC and is rewritten when col_cnt equals its group base.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NB; c++) begin : g_view
    assign cols[c] = work_q[4*c +: 4];
  end

  for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_lane
    assign col_idx[g] = col_cnt[IDX_W-1:0] + IDX_W'(g);
    assign col_in[g]  = cols[col_idx[g]];

    aes_mixcol_col u_col (
      .col_in  (col_in[g]),
      .mode    (mode_q),
      .col_out (col_out[g])
    );
  end

  for (genvar c = 0; c < NB; c++) begin : g_wb
    localparam logic [CNT_W-1:0] GRP_BASE = CNT_W'((c / COLS_PER_CYC) * COLS_PER_CYC);
    assign work_d[4*c +: 4] = (col_cnt == GRP_BASE) ? col_out[c % COLS_PER_CYC] : cols[c];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MC_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block covers
  // every path, so no latch is inferred for the cases that do not assign.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: if (in_valid)             state_d = MC_BUSY;
      MC_BUSY: if (col_cnt == LAST_CNT)  state_d = MC_DONE;
      MC_DONE: if (out_ready)            state_d = MC_IDLE;
      default:                           state_d = MC_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (state-only, never combinational on in_valid/out_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == MC_IDLE);
    out_valid = (state_q == MC_DONE);
    busy      = (state_q != MC_IDLE);
    out_state = (state_q == MC_DONE) ? work_q : '0;
  end

  // ---------------------------------------------------------------------------
  // Working register, column counter and captured mode
  // ---------------------------------------------------------------------------
  // NOTE: the working state is a plain register bank (not a RAM), so it is
  // cleared on reset; an aborted transaction leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work_q  <= '0;
      col_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        MC_IDLE: if (in_valid) begin
          work_q  <= in_state;
          mode_q  <= in_mode;
          col_cnt <= '0;
        end
        MC_BUSY: begin
          work_q  <= work_d;
          col_cnt <= col_cnt + CNT_STEP;
        end
        MC_DONE: if (out_ready) col_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_mixcol_engine
//   Three engines (COLS_PER_CYC = 1, 2, 4) share clock and reset. Directed
//   FIPS-197 vectors plus random states are compared against a generic
//   GF(2^8) matrix-multiply model.
// -----------------------------------------------------------------------------
module tb_aes_mixcol_engine;

  localparam int N_DUT = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid  [N_DUT];
  logic         in_mode   [N_DUT];
  logic         out_ready [N_DUT];
  logic [127:0] in_state  [N_DUT];
  logic         in_ready  [N_DUT];
  logic         out_valid [N_DUT];
  logic         busy      [N_DUT];
  logic [127:0] out_state [N_DUT];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < N_DUT; k++) begin : g_dut
    aes_mixcol_engine #(.NB(4), .COLS_PER_CYC(1 << k)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_mode   (in_mode[k]),
      .in_state  (in_state[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_state (out_state[k]),
      .busy      (busy[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model: state times the (inverse) MixColumns matrix over GF(2^8)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gf_mul(coef[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Offer a state and return #1 after the accept edge, with inputs scrambled.
  task automatic start_txn(input int k, input logic [127:0] s, input bit m);
    int n;
    in_state[k] = s;
    in_mode[k]  = m;
    in_valid[k] = 1'b1;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check($sformatf("accept_wait_d%0d", k), in_ready[k], 1'b1);
    @(posedge clock); #1;
    in_valid[k] = 1'b0;
    in_mode[k]  = ~m;
    in_state[k] = rnd128();
    check($sformatf("busy_after_accept_d%0d", k), {in_ready[k], busy[k]}, 2'b01);
  endtask

  // Wait for the result, hold it back for 'hold' cycles, then take it.
  // lat counts clock edges from the accept edge through the one raising out_valid.
  task automatic finish_txn(input int k, input int hold, output logic [127:0] res, output int lat);
    logic [127:0] held;
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check($sformatf("done_wait_d%0d", k), out_valid[k], 1'b1);
    res  = out_state[k];
    held = res;
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      in_state[k] = rnd128();
      @(posedge clock); #1;
      check($sformatf("hold_state_d%0d_c%0d", k, i), out_state[k], held);
      check($sformatf("hold_hs_d%0d_c%0d", k, i), {in_ready[k], out_valid[k]}, 2'b01);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clock); #1;
    out_ready[k] = 1'b0;
    check($sformatf("release_d%0d", k), {in_ready[k], out_valid[k], busy[k]}, 3'b100);
  endtask

  task automatic run_txn(input int k, input logic [127:0] s, input bit m, input int hold,
                         input logic [127:0] exp, input string tag);
    logic [127:0] res;
    int           lat;
    start_txn(k, s, m);
    finish_txn(k, hold, res, lat);
    check($sformatf("%s_d%0d", tag, k), res, exp);
    check($sformatf("%s_lat_d%0d", tag, k), lat, 4 / (1 << k) + 1);
  endtask

  localparam logic [127:0] T1_IN  = 128'hdb135345_db135345_db135345_db135345;
  localparam logic [127:0] T1_OUT = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc;
  localparam logic [127:0] T2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] T2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] T4_IN  = 128'h01010101_c6c6c6c6_f20a225c_00000000;
  localparam logic [127:0] T4_OUT = 128'h01010101_c6c6c6c6_9fdc589d_00000000;

  initial begin
    logic [127:0] s, res;
    bit           m;
    int           lat;

    reset = 1'b0;
    for (int k = 0; k < N_DUT; k++) begin
      in_valid[k]  = 1'b0;
      in_mode[k]   = 1'b0;
      out_ready[k] = 1'b0;
      in_state[k]  = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("reset_hs_d%0d", k), {in_ready[k], out_valid[k], busy[k]}, 3'b100);
      check($sformatf("reset_state_d%0d", k), out_state[k], '0);
    end
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed vectors on every column width.
    for (int k = 0; k < N_DUT; k++) begin
      run_txn(k, T1_IN,  1'b0, 0, T1_OUT, "t1_fwd_col");
      run_txn(k, T2_IN,  1'b0, 0, T2_OUT, "t2_fwd");
      run_txn(k, T2_OUT, 1'b1, 0, T2_IN,  "t3_inv");
    end

    // Identity-like, mixed and zero columns, both directions.
    run_txn(0, T4_IN,  1'b0, 0, T4_OUT, "t4_fwd");
    run_txn(0, T4_OUT, 1'b1, 0, T4_IN,  "t4_inv");
    run_txn(0, T4_IN,  1'b1, 0, ref_mix(T4_IN, 1'b1), "t4_inv_direct");

    // Random states and modes against the model.
    for (int k = 0; k < N_DUT; k++) begin
      for (int i = 0; i < 6; i++) begin
        s = rnd128();
        m = 1'($urandom_range(0, 1));
        run_txn(k, s, m, $urandom_range(0, 2), ref_mix(s, m), $sformatf("rand%0d", i));
      end
    end

    // Back-pressure for 10 cycles, then a back-to-back transaction.
    s = rnd128();
    run_txn(0, s, 1'b0, 10, ref_mix(s, 1'b0), "bp_first");
    s = rnd128();
    run_txn(0, s, 1'b1, 0, ref_mix(s, 1'b1), "bp_second");

    // Reset two cycles into BUSY: everything returns to reset values at once.
    start_txn(0, T2_IN, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("mid_reset_hs", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
    check("mid_reset_state", out_state[0], '0);
    @(posedge clock); #1;
    check("mid_reset_held", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
    reset = 1'b1;
    @(posedge clock); #1;
    start_txn(0, T2_IN, 1'b0);
    finish_txn(0, 0, res, lat);
    check("post_reset_result", res, T2_OUT);
    check("post_reset_lat", lat, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
